// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the regfile write arbiter.
// Register file geometry defaults and round-robin pointer encoding.
package regfile_write_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int DROP_CNT_W = 8;

  typedef enum logic {
    PTR_A = 1'b0,
    PTR_B = 1'b1
  } ptr_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker with a hold input.
// Ports: clk, rst_n, req[1:0] (0=A,1=B), hold -> one-hot gnt[1:0].
module rr_arbiter2
  import regfile_write_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       hold,
  output logic [1:0] gnt
);

  ptr_e r_ptr;

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      hold: gnt = 2'b00;
      (!hold && (&req)):
        gnt = (r_ptr == PTR_A) ? 2'b01 : 2'b10;
      default: gnt = req;
    endcase
  end

  // After a grant the other side gets priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= PTR_A;
    end else if (gnt[0]) begin
      r_ptr <= PTR_B;
    end else if (gnt[1]) begin
      r_ptr <= PTR_A;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates two writeback sources onto the single regfile write port.
// Ports: Clk, Reset_n, Hold, Valid/Ready/Addr/Data A and B,
//        WriteRegister, WriteData, RegWrite, DroppedCount.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = REG_DATA_W,
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int CNT_WIDTH  = DROP_CNT_W
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  Hold,
  input  logic                  ValidA,
  output logic                  ReadyA,
  input  logic [ADDR_WIDTH-1:0] AddrA,
  input  logic [DATA_WIDTH-1:0] DataA,
  input  logic                  ValidB,
  output logic                  ReadyB,
  input  logic [ADDR_WIDTH-1:0] AddrB,
  input  logic [DATA_WIDTH-1:0] DataB,
  output logic [ADDR_WIDTH-1:0] WriteRegister,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic                  RegWrite,
  output logic [CNT_WIDTH-1:0]  DroppedCount
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [1:0]            w_gnt;
  logic                  w_fire;
  logic                  w_zero;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;

  rr_arbiter2 u_arb (
    .clk   (Clk),
    .rst_n (Reset_n),
    .req   ({ValidB, ValidA}),
    .hold  (Hold),
    .gnt   (w_gnt)
  );

  assign ReadyA = w_gnt[0];
  assign ReadyB = w_gnt[1];
  assign w_fire = |w_gnt;
  assign w_addr = w_gnt[1] ? AddrB : AddrA;
  assign w_data = w_gnt[1] ? DataB : DataA;
  assign w_zero = (w_addr == '0);

  // r0 writes still load the issue register but never strobe.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      WriteRegister <= '0;
      WriteData     <= '0;
      RegWrite      <= 1'b0;
      DroppedCount  <= '0;
    end else begin
      RegWrite <= w_fire && !w_zero;
      if (w_fire) begin
        WriteRegister <= w_addr;
        WriteData     <= w_data;
      end
      if (w_fire && w_zero &&
          DroppedCount != CNT_MAX) begin
        DroppedCount <= DroppedCount + CNT_WIDTH'(1);
      end
    end
  end

endmodule
